// File: rtl/md_unit.sv
// Multiply/divide unit for the MIPS Execute stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// as a fixed-latency busy window and applies MTHI/MTLO immediately when idle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic        immWriteE,
    input  logic        E_valid,
    input  logic        flushE,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        startE_out,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic          acc, imm_ok;
    logic [63:0]   ext_a, ext_b, prod;
    logic [31:0]   divisor, sq, sr, uq, ur;
    logic          div_zero, div_ovf;
    logic [63:0]   result;

    // Valid/ready: a start is taken only when qualified and the unit is IDLE;
    // busy is the "not ready" indication back to the hazard unit.
    assign startE_out = startE & E_valid & ~flushE;
    assign acc        = startE_out & (state_q == IDLE) & ~MDOpE[2];
    assign imm_ok     = immWriteE & E_valid & ~flushE & (state_q == IDLE);

    // op_q[0] set means unsigned; op_q[1] set means divide.
    always_comb begin
        ext_a    = {{32{a_q[31] & ~op_q[0]}}, a_q};
        ext_b    = {{32{b_q[31] & ~op_q[0]}}, b_q};
        prod     = ext_a * ext_b;
        div_zero = (b_q == 32'd0);
        div_ovf  = ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
        divisor  = div_zero ? 32'd1 : b_q;
        sq       = 32'($signed(a_q) / $signed(divisor));
        sr       = 32'($signed(a_q) % $signed(divisor));
        uq       = a_q / divisor;
        ur       = a_q % divisor;
        if (!op_q[1])     result = prod;
        else if (div_zero) result = {a_q, 32'hFFFF_FFFF};
        else if (div_ovf)  result = {32'd0, 32'h8000_0000};
        else if (op_q[0])  result = {ur, uq};
        else               result = {sr, sq};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = RUN;
                    op_d    = MDOpE[1:0];
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = MDOpE[1] ? DIV_N : MULT_N;
                end else if (imm_ok) begin
                    if (MDOpE == 3'd4) hi_d = A;
                    if (MDOpE == 3'd5) lo_d = A;
                end
            end
            RUN: begin
                // A flush on the final edge still wins: no HI/LO write.
                if (flushE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == ONE) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    {hi_d, lo_d} = result;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign state_dbg = state_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-written flush/reset sequences and
// random back-to-back operations checked against an arithmetic reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, startE, immWriteE, E_valid, flushE;
    logic [2:0]  MDOpE;
    logic [31:0] A, B;
    logic        busy, startE_out, state_dbg;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .startE(startE), .immWriteE(immWriteE),
        .E_valid(E_valid), .flushE(flushE), .MDOpE(MDOpE), .A(A), .B(B),
        .busy(busy), .startE_out(startE_out), .HI(HI), .LO(LO), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          inj;
        int          exp_cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-precision integer arithmetic on 64-bit values.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int ia, ib;
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        ia = a; ib = b; sa = ia; sb = ib; ua = {32'd0, a}; ub = {32'd0, b};
        model = 64'd0;
        case (op)
            3'd0: model = sa * sb;
            3'd1: model = ua * ub;
            3'd2: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb; r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub; ur = ua % ub;
                    model = {ur[31:0], uq[31:0]};
                end
            end
        endcase
    endfunction

    // Called just after a falling edge; returns at a falling edge with busy low,
    // so consecutive calls issue back-to-back starts. inj: 1 MTLO mid-run,
    // 2 stray start mid-run, 3 flush in busy cycle 4.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  cyc;
        bit  done;
        startE = 1'b1; E_valid = 1'b1; flushE = 1'b0; immWriteE = 1'b0;
        MDOpE = op; A = a; B = b;
        #1;
        check({tag, "_start_out"}, {31'd0, startE_out}, 32'd1);
        @(posedge clk); #1;
        startE = 1'b0; A = $urandom; B = $urandom;
        cyc = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            startE = 1'b0; immWriteE = 1'b0; flushE = 1'b0;
            if (busy) begin
                cyc++;
                if (inj == 1 && cyc == 2) begin immWriteE = 1'b1; MDOpE = 3'd5; end
                if (inj == 2 && cyc == 2) begin startE = 1'b1; MDOpE = 3'd2; end
                if (inj == 3 && cyc == 4) flushE = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        logic [63:0] r_exp;
        int          nbusy;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        0, 5,  32'd2,         32'hFFFF_FFFA};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd7,         32'd0,        0, 10, 32'd7,         32'hFFFF_FFFF};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 10, 32'd0,        32'h8000_0000};
        vecs[5] = '{3'd0, 32'd6,         32'd7,        1, 5,  32'd0,         32'd42};
        vecs[6] = '{3'd2, 32'd100,       32'd3,        3, 4,  32'd0,         32'd42};
        vecs[7] = '{3'd1, 32'd3,         32'd4,        0, 5,  32'd0,         32'd12};
        vecs[8] = '{3'd3, 32'd100,       32'd7,        0, 10, 32'd2,         32'd14};
        vecs[9] = '{3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 2, 5, 32'd0,         32'd15};

        // Reset and idle
        reset = 1'b0; startE = 1'b1; immWriteE = 1'b0; E_valid = 1'b0; flushE = 1'b0;
        MDOpE = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_start_out_invalid", {31'd0, startE_out}, 32'd0);
        reset = 1'b1; startE = 1'b0;
        @(negedge clk);

        // MTHI / MTLO while idle
        immWriteE = 1'b1; E_valid = 1'b1; MDOpE = 3'd4; A = 32'h1234_5678;
        @(posedge clk); #1;
        immWriteE = 1'b0;
        check("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_lo_kept", LO, 32'd0);
        immWriteE = 1'b1; MDOpE = 3'd5; A = 32'hCAFE_F00D;
        @(posedge clk); #1;
        immWriteE = 1'b0;
        @(negedge clk);
        check("mtlo_lo", LO, 32'hCAFE_F00D);
        check("mtlo_hi_kept", HI, 32'h1234_5678);

        // Directed vector table; entries 7 and 8 run back-to-back
        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inj,
                  vecs[i].exp_cyc, vecs[i].exp_hi, vecs[i].exp_lo);

        // Flush coincident with a start: nothing accepted
        startE = 1'b1; E_valid = 1'b1; flushE = 1'b1; MDOpE = 3'd2; A = 32'd100; B = 32'd3;
        #1;
        check("flush_start_out", {31'd0, startE_out}, 32'd0);
        @(posedge clk); #1;
        startE = 1'b0; flushE = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        check("flush_start_busy_cycles", 32'(nbusy), 32'd0);
        check("flush_start_hi", HI, 32'd0);
        check("flush_start_lo", LO, 32'd15);

        // Random back-to-back operations against the reference model
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            if (i == 5) begin r_op = 3'd2; r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            r_exp = model(r_op, r_a, r_b);
            do_op($sformatf("rnd%0d", i), r_op, r_a, r_b, 0, (r_op < 3'd2) ? 5 : 10,
                  r_exp[63:32], r_exp[31:0]);
        end

        // Asynchronous reset mid-MULT
        startE = 1'b1; E_valid = 1'b1; MDOpE = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        startE = 1'b0;
        @(negedge clk);
        check("areset_running", {31'd0, busy}, 32'd1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_hi", HI, 32'd0);
        check("areset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("areset_no_late_write_hi", HI, 32'd0);
        check("areset_no_late_write_lo", LO, 32'd0);
        check("areset_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
